// File: rtl/fpdiv_ctrl.sv
// Sequencer for a Goldschmidt divider: steers the multiplier operand muxes and
// the rega/regb/regc load enables, alternating quotient and divisor refinement.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// D0    | regb <= approx*denom, regc <= 2 - approx*denom, count = 1
// N0    | rega <= approx*num
// NSTEP | rega <= regc*rega; finish once count reaches ITER
// DSTEP | regb <= regc*regb, regc <= 2 - regc*regb, count + 1
// DONE  | one-cycle done pulse, rega holds the quotient
module fpdiv_ctrl #(
   parameter int unsigned ITER = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   output logic       sel_mux2,
   output logic [1:0] sel_mux4,
   output logic       en_a,
   output logic       en_b,
   output logic       en_c,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_D0,
      S_N0,
      S_NSTEP,
      S_DSTEP,
      S_DONE
   } state_t;

   localparam logic [2:0] ITER_C = 3'(ITER);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_D0;
         S_D0: begin
            cnt_d   = 3'd1;
            state_d = S_N0;
         end
         S_N0:    state_d = S_NSTEP;
         S_NSTEP: state_d = (cnt_q == ITER_C) ? S_DONE : S_DSTEP;
         S_DSTEP: begin
            cnt_d   = cnt_q + 3'd1;
            state_d = S_NSTEP;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // abort wins over every transition, but a request in IDLE still starts
      if (abort && state_q != S_IDLE) state_d = S_IDLE;
   end

   always_comb begin
      sel_mux2 = 1'b0;
      sel_mux4 = 2'd0;
      en_a     = 1'b0;
      en_b     = 1'b0;
      en_c     = 1'b0;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      case (state_q)
         S_D0: begin
            sel_mux4 = 2'd1;
            en_b     = 1'b1;
            en_c     = 1'b1;
         end
         S_N0: begin
            en_a = 1'b1;
         end
         S_NSTEP: begin
            sel_mux2 = 1'b1;
            sel_mux4 = 2'd2;
            en_a     = 1'b1;
         end
         S_DSTEP: begin
            sel_mux2 = 1'b1;
            sel_mux4 = 2'd3;
            en_b     = 1'b1;
            en_c     = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Bench for fpdiv_ctrl: directed operations push per-cycle expected outputs and
// done cycles into queues; a negedge monitor pops and compares them.
module tb_fpdiv_ctrl;

   logic clk = 1'b0;
   logic reset, start0, start1, abort;

   logic       s2_0, s2_1, ea0, ea1, eb0, eb1, ec0, ec1, busy0, busy1, done0, done1;
   logic [1:0] s4_0, s4_1;
   logic [7:0] vec0, vec1;

   fpdiv_ctrl #(.ITER(3)) u_dut (
      .clk(clk), .reset(reset), .start(start0), .abort(abort),
      .sel_mux2(s2_0), .sel_mux4(s4_0), .en_a(ea0), .en_b(eb0), .en_c(ec0),
      .busy(busy0), .done(done0)
   );

   fpdiv_ctrl #(.ITER(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .abort(abort),
      .sel_mux2(s2_1), .sel_mux4(s4_1), .en_a(ea1), .en_b(eb1), .en_c(ec1),
      .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   assign vec0 = {busy0, done0, ea0, eb0, ec0, s2_0, s4_0};
   assign vec1 = {busy1, done1, ea1, eb1, ec1, s2_1, s4_1};

   // {busy, done, en_a, en_b, en_c, sel_mux2, sel_mux4}
   localparam logic [7:0] V_IDLE = 8'b0000_0000;
   localparam logic [7:0] V_D0   = 8'b1001_1001;
   localparam logic [7:0] V_N0   = 8'b1010_0000;
   localparam logic [7:0] V_NS   = 8'b1010_0110;
   localparam logic [7:0] V_DS   = 8'b1001_1111;
   localparam logic [7:0] V_DN   = 8'b1100_0000;

   typedef struct {
      int         cyc;
      logic [7:0] vec;
   } exp_t;

   exp_t q0[$], q1[$];
   int   dq0[$], dq1[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath model in Q2.30 driven by the controller, to confirm the quotient
   localparam longint ONE    = 64'sd1 << 30;
   localparam longint APPROX = 64'sd671088640;
   localparam longint NUM    = 64'sh800000 << 7;
   localparam longint DEN    = 64'shC00000 << 7;
   longint rega = 0, regb = 0, regc = 0;
   longint op_a, op_b, prod, q24;

   always @(posedge clk) begin
      op_a = s2_0 ? regc : APPROX;
      case (s4_0)
         2'd0:    op_b = NUM;
         2'd1:    op_b = DEN;
         2'd2:    op_b = rega;
         default: op_b = regb;
      endcase
      prod = (op_a * op_b + (64'sd1 <<< 29)) >>> 30;
      if (ea0) rega <= prod;
      if (eb0) regb <= prod;
      if (ec0) regc <= 2 * ONE - prod;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (q0.size() > 0 && q0[0].cyc <= cyc) begin
         e = q0.pop_front();
         if (e.cyc < cyc) check("vec0_skipped", 32'(e.cyc), 32'(cyc));
         else check("vec_iter3", 32'(vec0), 32'(e.vec));
      end
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
         e = q1.pop_front();
         if (e.cyc < cyc) check("vec1_skipped", 32'(e.cyc), 32'(cyc));
         else check("vec_iter1", 32'(vec1), 32'(e.vec));
      end
      while (dq0.size() > 0 && dq0[0] < cyc) check("done0_missed", 32'(cyc), 32'(dq0.pop_front()));
      while (dq1.size() > 0 && dq1[0] < cyc) check("done1_missed", 32'(cyc), 32'(dq1.pop_front()));
      if (done0) begin
         if (dq0.size() == 0 || dq0[0] != cyc) check("done0_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         else begin
            check("done0_cycle", 32'(cyc), 32'(dq0.pop_front()));
            q24 = (rega + 32) >>> 6;
            check("quotient_1ulp", 32'((q24 >= 64'shAAAAAA && q24 <= 64'shAAAAAC) ? q24 : 0),
                  32'(q24));
         end
      end
      if (done1) begin
         if (dq1.size() == 0 || dq1[0] != cyc) check("done1_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         else check("done1_cycle", 32'(cyc), 32'(dq1.pop_front()));
      end
   end

   task automatic push0(input int c, input logic [7:0] v);
      exp_t x;
      x.cyc = c;
      x.vec = v;
      q0.push_back(x);
   endtask

   task automatic push1(input int c, input logic [7:0] v);
      exp_t x;
      x.cyc = c;
      x.vec = v;
      q1.push_back(x);
   endtask

   task automatic push_idle(input int inst, input int from, input int n);
      for (int i = 0; i < n; i++) begin
         if (inst == 0) push0(from + i, V_IDLE);
         else push1(from + i, V_IDLE);
      end
   endtask

   // Full ITER=3 operation when start is sampled at the end of cycle t
   task automatic push_op3(input int t);
      push0(t + 1, V_D0);
      push0(t + 2, V_N0);
      push0(t + 3, V_NS);
      push0(t + 4, V_DS);
      push0(t + 5, V_NS);
      push0(t + 6, V_DS);
      push0(t + 7, V_NS);
      push0(t + 8, V_DN);
      push0(t + 9, V_IDLE);
      dq0.push_back(t + 8);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      abort  = 1'b0;
      push_idle(0, 1, 2);
      push_idle(1, 1, 2);

      // first start right after reset release, with datapath quotient check
      wait_cyc(3);
      #2 reset = 1'b0;
      start0 = 1'b1;
      push_op3(3);
      push_idle(1, 4, 8);
      @(negedge clk) start0 = 1'b0;

      // ITER=1: D0, N0, NSTEP, DONE
      wait_cyc(14);
      start1 = 1'b1;
      push1(15, V_D0);
      push1(16, V_N0);
      push1(17, V_NS);
      push1(18, V_DN);
      push1(19, V_IDLE);
      dq1.push_back(18);
      push_idle(0, 15, 5);
      @(negedge clk) start1 = 1'b0;

      // abort together with start in IDLE still launches a division
      wait_cyc(22);
      start0 = 1'b1;
      abort  = 1'b1;
      push_op3(22);
      @(negedge clk);
      start0 = 1'b0;
      abort  = 1'b0;

      // abort in the second DSTEP: no done, no further rega writes
      wait_cyc(33);
      start0 = 1'b1;
      push0(34, V_D0);
      push0(35, V_N0);
      push0(36, V_NS);
      push0(37, V_DS);
      push0(38, V_NS);
      push0(39, V_DS);
      push_idle(0, 40, 3);
      @(negedge clk) start0 = 1'b0;
      wait_cyc(39);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;

      // start held high: operations begin 9 cycles apart
      wait_cyc(44);
      start0 = 1'b1;
      push_op3(44);
      push_op3(53);
      push_op3(62);
      wait_cyc(63);
      start0 = 1'b0;

      // asynchronous reset pulse inside NSTEP
      wait_cyc(74);
      start0 = 1'b1;
      push0(75, V_D0);
      push0(76, V_N0);
      push0(77, V_NS);
      @(negedge clk) start0 = 1'b0;
      wait_cyc(77);
      #1 reset = 1'b1;
      #1 check("async_reset_outputs", 32'(vec0), 32'(V_IDLE));
      #1 reset = 1'b0;
      push_idle(0, 78, 5);

      wait_cyc(85);
      check("leftover_vec0", 32'(q0.size()), 32'd0);
      check("leftover_vec1", 32'(q1.size()), 32'd0);
      check("leftover_done0", 32'(dq0.size()), 32'd0);
      check("leftover_done1", 32'(dq1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 The module SHALL have parameter ITER, default 3, giving the number of Goldschmidt refinement iterations; legal range 1..7.
REQ-002 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to begin a division; num/denom are held stable by the requester from start until done.
REQ-005 Port abort, input, 1 bit: cancel an in-flight division.
REQ-006 Port sel_mux2, output, 1 bit: multiplier operand A select; 0 = initial approximation, 1 = regc.
REQ-007 Port sel_mux4, output, 2 bits: multiplier operand B select; 0 = num, 1 = denom, 2 = rega, 3 = regb.
REQ-008 Port en_a, output, 1 bit: load enable for rega (numerator/quotient register).
REQ-009 Port en_b, output, 1 bit: load enable for regb (denominator register).
REQ-010 Port en_c, output, 1 bit: load enable for regc (correction factor, two's complement of rounded product).
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse; rega holds the final quotient while done is high.

Function
REQ-013 The controller SHALL be a Moore FSM with states IDLE, D0, N0, NSTEP, DSTEP, DONE; all outputs are decoded from state and iteration counter only.
REQ-014 IDLE: sel_mux2=0, sel_mux4=0, all enables 0; start=1 -> D0, otherwise remain.
REQ-015 D0: sel_mux2=0, sel_mux4=1, en_b=1, en_c=1; counter cleared to 1; unconditionally -> N0.
REQ-016 N0: sel_mux2=0, sel_mux4=0, en_a=1; unconditionally -> NSTEP.
REQ-017 NSTEP: sel_mux2=1, sel_mux4=2, en_a=1; counter==ITER -> DONE, else -> DSTEP.
REQ-018 DSTEP: sel_mux2=1, sel_mux4=3, en_b=1, en_c=1; counter increments by 1; -> NSTEP.
REQ-019 DONE: done=1, all enables 0, sel outputs 0; unconditionally -> IDLE.
REQ-020 The iteration counter SHALL be 3 bits wide; it never wraps for legal ITER.
REQ-021 Latency: start sampled high at edge t places the FSM in D0 at cycle t+1; done is high in cycle t+2*ITER+2.
REQ-022 At most one enable group SHALL be active per cycle; en_a and en_b are never both high.
REQ-023 start SHALL be ignored in every state except IDLE, including DONE; back-to-back operation begins at the earliest in the cycle after DONE.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse; abort has priority over all transitions; abort in IDLE has no effect.
REQ-025 abort and start both high in IDLE SHALL start a division (abort ignored).

Reset
REQ-026 reset=1 SHALL force IDLE and counter=0 immediately, without waiting for clk; all outputs are 0 while reset is high.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no done pulse is produced after release.
REQ-028 After reset deassertion, the first start is accepted at the next rising edge.

Verification
REQ-029 ITER=3, start pulsed at cycle 0 -> states D0,N0,NSTEP,DSTEP,NSTEP,DSTEP,NSTEP in cycles 1..7; done=1 in cycle 8 only; busy high in cycles 1..8.
REQ-030 ITER=3, num=0x800000 (1.0), denom=0xC00000 (1.5) with real datapath -> rega at done is within 1 ulp of 0xAAAAAB.
REQ-031 ITER=1 -> sequence D0,N0,NSTEP,DONE; done in cycle 4; no DSTEP is ever entered.
REQ-032 abort asserted during the second DSTEP (cycle 6, ITER=3) -> IDLE in cycle 7, done never asserted, rega not written after cycle 5.
REQ-033 start held high continuously -> new operations begin in cycles 1, 10, 19 (one IDLE cycle between DONE and D0).
REQ-034 reset pulsed asynchronously between edges in NSTEP -> busy and all enables drop to 0 before the next clk edge; FSM remains IDLE until start.
